// File: rtl/prefix_pkg.sv
// prefix_pkg: shared definitions for the Kogge-Stone prefix adders.
//   PFX_WIDTH  - default operand width
//   op_e       - add/subtract selector encoding
//   pfx_levels - number of prefix levels for a given width; the combinational
//                adder and the pipelined adder use it so both stay aligned.
package prefix_pkg;

  localparam int PFX_WIDTH = 32;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int pfx_levels(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/prefix_addsub_pipe_level.sv
// prefix_level: one combinational Kogge-Stone level.
//   WIDTH - vector width
//   DIST  - span of this level (bit i combines with bit i-DIST)
//   g_i/p_i - group generate/propagate into the level
//   g_o/p_o - group generate/propagate out of the level
module prefix_level #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (gi >= DIST) begin : g_comb
      assign g_o[gi] = g_i[gi] | (p_i[gi] & g_i[gi-DIST]);
      assign p_o[gi] = p_i[gi] & p_i[gi-DIST];
    end else begin : g_pass
      // Low bits already span down to bit 0; they pass through unchanged.
      assign g_o[gi] = g_i[gi];
      assign p_o[gi] = p_i[gi];
    end
  end

endmodule

// File: rtl/prefix_addsub_pipe.sv
// prefix_addsub_pipe: two-stage pipelined Kogge-Stone adder/subtractor with
// valid/ready handshakes on input and output.
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - operand beat handshake
//   in_a, in_b            - operands
//   in_cb                 - carry-in (add) / borrow-in (sub)
//   in_sub                - 0 = A+B+cin, 1 = A-B-bin
//   out_valid/out_ready   - result beat handshake
//   out_res               - sum / difference (wraps modulo 2^WIDTH)
//   out_cb                - carry-out (add) / borrow-out (sub)
//   out_ovf               - signed overflow
//   out_zero              - out_res == 0
module prefix_addsub_pipe
  import prefix_pkg::*;
#(
  parameter int WIDTH = PFX_WIDTH,
  parameter int SPLIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cb,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cb,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int LEVELS    = pfx_levels(WIDTH);
  // A SPLIT larger than the level count just puts every level in stage 1.
  localparam int S1_LEVELS = (SPLIT < LEVELS) ? SPLIT : LEVELS;
  localparam int S2_LEVELS = LEVELS - S1_LEVELS;

  // ---------------- handshake ----------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_adv, s2_adv;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;

  // ---------------- stage 1 combinational ----------------
  op_e              in_op;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] g_bit;

  always_comb begin
    in_op = op_e'(in_sub);
    b_eff = (in_op == OP_SUB) ? ~in_b : in_b;
    c_eff = (in_op == OP_SUB) ? ~in_cb : in_cb;
    p_bit = in_a ^ b_eff;
    g_bit = in_a & b_eff;
    // Folding the carry-in into bit 0 makes every final group generate the
    // carry out of its bit, including c_eff.
    g_bit[0] = g_bit[0] | (p_bit[0] & c_eff);
  end

  logic [WIDTH-1:0] s1_g [S1_LEVELS+1];
  logic [WIDTH-1:0] s1_p [S1_LEVELS+1];

  assign s1_g[0] = g_bit;
  assign s1_p[0] = p_bit;

  for (genvar gi = 0; gi < S1_LEVELS; gi++) begin : g_s1_lvl
    prefix_level #(
      .WIDTH(WIDTH),
      .DIST (1 << gi)
    ) u_level (
      .g_i(s1_g[gi]),
      .p_i(s1_p[gi]),
      .g_o(s1_g[gi+1]),
      .p_o(s1_p[gi+1])
    );
  end

  // ---------------- stage 1 registers ----------------
  logic [WIDTH-1:0] s1_g_q, s1_g_d;
  logic [WIDTH-1:0] s1_p_q, s1_p_d;
  logic [WIDTH-1:0] s1_p0_q, s1_p0_d;
  logic             s1_a_msb_q, s1_a_msb_d;
  logic             s1_b_msb_q, s1_b_msb_d;
  logic             s1_c_q, s1_c_d;
  op_e              s1_op_q, s1_op_d;

  // ---------------- stage 2 combinational ----------------
  logic [WIDTH-1:0] s2_g [S2_LEVELS+1];
  logic [WIDTH-1:0] s2_p [S2_LEVELS+1];

  assign s2_g[0] = s1_g_q;
  assign s2_p[0] = s1_p_q;

  for (genvar gi = 0; gi < S2_LEVELS; gi++) begin : g_s2_lvl
    prefix_level #(
      .WIDTH(WIDTH),
      .DIST (1 << (S1_LEVELS + gi))
    ) u_level (
      .g_i(s2_g[gi]),
      .p_i(s2_p[gi]),
      .g_o(s2_g[gi+1]),
      .p_o(s2_p[gi+1])
    );
  end

  // The whole-word group propagate is not needed; only carries matter.
  logic unused_p_all;
  assign unused_p_all = &s2_p[S2_LEVELS];

  logic [WIDTH-1:0] carries;
  logic [WIDTH-1:0] res2;
  logic             cout2;
  logic             cb2;
  logic             ovf2;
  logic             zero2;

  always_comb begin
    carries = s2_g[S2_LEVELS];
    res2    = s1_p0_q ^ {carries[WIDTH-2:0], s1_c_q};
    cout2   = carries[WIDTH-1];
    // A subtract borrows exactly when the inverted-operand add does not carry.
    cb2     = (s1_op_q == OP_SUB) ? ~cout2 : cout2;
    ovf2    = (s1_a_msb_q == s1_b_msb_q) && (res2[WIDTH-1] != s1_a_msb_q);
    zero2   = ~|res2;
  end

  // ---------------- stage 2 / output registers ----------------
  logic [WIDTH-1:0] out_res_q, out_res_d;
  logic             out_cb_q, out_cb_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_zero_q, out_zero_d;

  assign out_res  = out_res_q;
  assign out_cb   = out_cb_q;
  assign out_ovf  = out_ovf_q;
  assign out_zero = out_zero_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_g_d     = s1_g_q;
    s1_p_d     = s1_p_q;
    s1_p0_d    = s1_p0_q;
    s1_a_msb_d = s1_a_msb_q;
    s1_b_msb_d = s1_b_msb_q;
    s1_c_d     = s1_c_q;
    s1_op_d    = s1_op_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_g_d     = s1_g[S1_LEVELS];
        s1_p_d     = s1_p[S1_LEVELS];
        s1_p0_d    = p_bit;
        s1_a_msb_d = in_a[WIDTH-1];
        s1_b_msb_d = b_eff[WIDTH-1];
        s1_c_d     = c_eff;
        s1_op_d    = in_op;
      end
    end

    s2_valid_d = s2_valid_q;
    out_res_d  = out_res_q;
    out_cb_d   = out_cb_q;
    out_ovf_d  = out_ovf_q;
    out_zero_d = out_zero_q;
    // Output fields only change when the stage is free to advance, so they
    // stay frozen while a result waits on out_ready.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_res_d  = res2;
        out_cb_d   = cb2;
        out_ovf_d  = ovf2;
        out_zero_d = zero2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_g_q     <= '0;
      s1_p_q     <= '0;
      s1_p0_q    <= '0;
      s1_a_msb_q <= 1'b0;
      s1_b_msb_q <= 1'b0;
      s1_c_q     <= 1'b0;
      s1_op_q    <= OP_ADD;
      out_res_q  <= '0;
      out_cb_q   <= 1'b0;
      out_ovf_q  <= 1'b0;
      out_zero_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_g_q     <= s1_g_d;
      s1_p_q     <= s1_p_d;
      s1_p0_q    <= s1_p0_d;
      s1_a_msb_q <= s1_a_msb_d;
      s1_b_msb_q <= s1_b_msb_d;
      s1_c_q     <= s1_c_d;
      s1_op_q    <= s1_op_d;
      out_res_q  <= out_res_d;
      out_cb_q   <= out_cb_d;
      out_ovf_q  <= out_ovf_d;
      out_zero_q <= out_zero_d;
    end
  end

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// tb_prefix_addsub_pipe: directed checks of prefix_addsub_pipe -- reset state,
// a table of hand-computed add/sub vectors, a backpressure stream and a
// mid-flight reset.
module tb_prefix_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_cb = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_res;
  logic        out_cb;
  logic        out_ovf;
  logic        out_zero;

  prefix_addsub_pipe #(.WIDTH(32), .SPLIT(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cb    (in_cb),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .out_cb   (out_cb),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        cb;
    logic [31:0] res;
    logic        cbo;
    logic        ovf;
    logic        zero;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference using wide integer arithmetic.
  function automatic vec_t model(input logic sub, input logic [31:0] a,
                                 input logic [31:0] b, input logic cb);
    vec_t        v;
    logic [32:0] s;
    v.sub = sub; v.a = a; v.b = b; v.cb = cb;
    if (!sub) begin
      s     = {1'b0, a} + {1'b0, b} + {32'd0, cb};
      v.ovf = (a[31] == b[31]) && (s[31] != a[31]);
    end else begin
      s     = {1'b0, a} - {1'b0, b} - {32'd0, cb};
      v.ovf = (a[31] != b[31]) && (s[31] != a[31]);
    end
    v.res  = s[31:0];
    v.cbo  = s[32];
    v.zero = (s[31:0] == 32'd0);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_sub = v.sub; in_a = v.a; in_b = v.b; in_cb = v.cb;
  endtask

  task automatic chk_out(input string tag, input vec_t v);
    chk({tag, "_res"},  out_res,  v.res);
    chk({tag, "_cb"},   {31'd0, out_cb},   {31'd0, v.cbo});
    chk({tag, "_ovf"},  {31'd0, out_ovf},  {31'd0, v.ovf});
    chk({tag, "_zero"}, {31'd0, out_zero}, {31'd0, v.zero});
  endtask

  // Entered just after a rising edge; pushes one beat and checks it two
  // register stages later.
  task automatic run_vec(input string tag, input vec_t v);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_valid_early"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk_out(tag, v);
    $display("%s: sub=%0b a=%h b=%h cb=%0b -> res=%h cb=%0b ovf=%0b zero=%0b",
             tag, v.sub, v.a, v.b, v.cb, out_res, out_cb, out_ovf, out_zero);
  endtask

  vec_t vecs[11];
  vec_t strm[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int got;
    vec_t v;

    //          sub   a             b             cb    res           cbo   ovf   zero
    vecs[0]  = '{1'b1, 32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h87654321, 32'h12345678, 1'b0, 32'h7530ECA9, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000000A, 32'h00000003, 1'b1, 32'h00000006, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h12345678, 32'h0FEDCBA9, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0};

    strm[0] = model(1'b0, 32'h00000001, 32'h00000002, 1'b0);
    strm[1] = model(1'b1, 32'h00000010, 32'h00000020, 1'b0);
    strm[2] = model(1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    strm[3] = model(1'b1, 32'h80000000, 32'h00000001, 1'b1);
    strm[4] = model(1'b0, 32'hDEADBEEF, 32'h01234567, 1'b1);
    strm[5] = model(1'b1, 32'h00000005, 32'h00000005, 1'b0);

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_res",   out_res, 32'd0);
    chk("rst_out_cb",    {31'd0, out_cb},   32'd0);
    chk("rst_out_ovf",   {31'd0, out_ovf},  32'd0);
    chk("rst_out_zero",  {31'd0, out_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 11; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end
    @(posedge clk); #1;

    // ---------------- backpressure stream ----------------
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (sent < 6);
      if (sent < 6) drive(strm[sent]);
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        chk($sformatf("bp_in_ready_c%0d", cyc), {31'd0, in_ready}, 32'd0);
        chk($sformatf("bp_accepts_c%0d", cyc), sent, 32'd2);
        chk($sformatf("bp_hold_valid_c%0d", cyc), {31'd0, out_valid}, 32'd1);
        chk_out($sformatf("bp_hold_c%0d", cyc), strm[0]);
      end
      if (out_valid && out_ready) begin
        chk_out($sformatf("bp_beat%0d", got), strm[got]);
        $display("stream beat %0d: res=%h cb=%0b ovf=%0b zero=%0b",
                 got, out_res, out_cb, out_ovf, out_zero);
        got++;
      end else if (got > 0) begin
        chk($sformatf("bp_gap_c%0d", cyc), {31'd0, out_valid}, 32'd1);
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_count", got, 32'd6);
    #1;
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // ---------------- reset with beats in flight ----------------
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(model(1'b0, 32'h00000100 + k, 32'h00000001, 1'b0));
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("inflight_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_res",   out_res, 32'd0);
    $display("async reset applied with 2 beats in flight");
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_idle%0d", k), {31'd0, out_valid}, 32'd0);
    end
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    v = '{1'b1, 32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
    run_vec("post_rst", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
